// File: rtl/decrypt_seq_pkg.sv
// ============================================================
// Package : decrypt_seq_pkg
// Shared state encoding and default sizing for the decrypt sequencer.
// Rev     : 1.0
// ============================================================
`default_nettype none

package decrypt_seq_pkg;

    localparam int C_ARQ_DEFAULT       = 16;
    localparam int C_ADDR_DEFAULT      = 10;
    localparam int C_BUF_DEPTH_DEFAULT = 64;
    localparam int C_TIMEOUT_DEFAULT   = 65535;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_CLEAR  = 3'd2,
        S_RUN    = 3'd3,
        S_STORE  = 3'd4,
        S_FINISH = 3'd5,
        S_FAULT  = 3'd6
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/decrypt_sequencer_if.sv
// ============================================================
// Interface : decrypt_sequencer_if
// Host control, engine handshake and result read port of the sequencer.
// Rev       : 1.0
// ============================================================
`default_nettype none

interface decrypt_sequencer_if
    import decrypt_seq_pkg::*;
#(
    parameter int ARQ       = C_ARQ_DEFAULT,
    parameter int ADDR      = C_ADDR_DEFAULT,
    parameter int BUF_DEPTH = C_BUF_DEPTH_DEFAULT
) ();

    logic                           start;
    logic [ADDR-1:0]                base_addr;
    logic [$clog2(BUF_DEPTH):0]     num_words;
    logic [ADDR-1:0]                address;
    logic                           eng_rst;
    logic                           eng_finish;
    logic [ARQ-1:0]                 eng_result;
    logic                           busy;
    logic                           done;
    logic                           error;
    logic [$clog2(BUF_DEPTH):0]     words_done;
    logic [$clog2(BUF_DEPTH)-1:0]   rd_addr;
    logic [ARQ-1:0]                 rd_data;

    modport master (
        output start, base_addr, num_words, eng_finish, eng_result, rd_addr,
        input  address, eng_rst, busy, done, error, words_done, rd_data
    );

    modport slave (
        input  start, base_addr, num_words, eng_finish, eng_result, rd_addr,
        output address, eng_rst, busy, done, error, words_done, rd_data
    );

endinterface

`default_nettype wire

// File: rtl/result_ram.sv
// ============================================================
// Module : result_ram
// Single write port, registered read port buffer; array is never reset.
// Rev    : 1.0
// ============================================================
`default_nettype none

module result_ram
    import decrypt_seq_pkg::*;
#(
    parameter int ARQ       = C_ARQ_DEFAULT,
    parameter int BUF_DEPTH = C_BUF_DEPTH_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [$clog2(BUF_DEPTH)-1:0]  wr_addr,
    input  logic [ARQ-1:0]                wr_data,
    input  logic [$clog2(BUF_DEPTH)-1:0]  rd_addr,
    output logic [ARQ-1:0]                rd_data
);

    logic [ARQ-1:0] r_mem [BUF_DEPTH];
    logic [ARQ-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    // Read samples the array before a same-cycle write lands: old data wins.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_data <= '0;
        end else begin
            r_rd_data <= r_mem[rd_addr];
        end
    end

    assign rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/decrypt_sequencer.sv
// ============================================================
// Module : decrypt_sequencer
// Walks a ciphertext address range through the decrypt engine, buffers results.
// Rev    : 1.0
// ============================================================
`default_nettype none

module decrypt_sequencer
    import decrypt_seq_pkg::*;
#(
    parameter int ARQ       = C_ARQ_DEFAULT,
    parameter int ADDR      = C_ADDR_DEFAULT,
    parameter int BUF_DEPTH = C_BUF_DEPTH_DEFAULT,
    parameter int TIMEOUT   = C_TIMEOUT_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    decrypt_sequencer_if.slave  bus
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int IW = $clog2(BUF_DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] C_MAX_WORDS = CW'(BUF_DEPTH);
    localparam logic [TW-1:0] C_TMO_LAST  = TW'(TIMEOUT - 1);

    seq_state_t      r_state;
    seq_state_t      w_next;
    logic [ADDR-1:0] r_base;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_idx;
    logic [TW-1:0]   r_tmo;
    logic            r_error;
    logic            w_wr_en;
    logic [CW-1:0]   w_idx_inc;
    logic [CW-1:0]   w_count_clamped;
    logic [ARQ-1:0]  w_rd_data;

    assign w_count_clamped = (bus.num_words > C_MAX_WORDS) ? C_MAX_WORDS : bus.num_words;
    assign w_idx_inc       = r_idx + CW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (w_count_clamped == '0) ? S_FINISH : S_SETUP;
                end
            end
            S_SETUP:  w_next = S_CLEAR;
            S_CLEAR:  w_next = S_RUN;
            S_RUN: begin
                if (bus.eng_finish) begin
                    w_next = S_STORE;
                end else if (r_tmo == C_TMO_LAST) begin
                    w_next = S_FAULT;
                end
            end
            S_STORE: begin
                w_wr_en = 1'b1;
                w_next  = (w_idx_inc == r_count) ? S_FINISH : S_SETUP;
            end
            S_FINISH: w_next = S_IDLE;
            S_FAULT:  w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Batch bookkeeping; the word index doubles as the stored-word count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_base  <= '0;
            r_count <= '0;
            r_idx   <= '0;
            r_tmo   <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_base  <= bus.base_addr;
                        r_count <= w_count_clamped;
                        r_idx   <= '0;
                        r_error <= 1'b0;
                    end
                end
                S_CLEAR: r_tmo <= '0;
                S_RUN: begin
                    if (!bus.eng_finish) begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_STORE: r_idx <= w_idx_inc;
                default: ;
            endcase
            if (w_next == S_FAULT) begin
                r_error <= 1'b1;
            end
        end
    end

    assign bus.address    = r_base + ADDR'(r_idx);
    assign bus.eng_rst    = (r_state != S_CLEAR);
    assign bus.busy       = (r_state inside {S_SETUP, S_CLEAR, S_RUN, S_STORE, S_FINISH});
    assign bus.done       = (r_state == S_FINISH);
    assign bus.error      = r_error;
    assign bus.words_done = r_idx;

    result_ram #(
        .ARQ       (ARQ),
        .BUF_DEPTH (BUF_DEPTH)
    ) u_result_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_wr_en),
        .wr_addr (r_idx[IW-1:0]),
        .wr_data (bus.eng_result),
        .rd_addr (bus.rd_addr),
        .rd_data (w_rd_data)
    );

    assign bus.rd_data = w_rd_data;

endmodule

`default_nettype wire

// File: tb/tb_decrypt_sequencer.sv
// ============================================================
// Module : tb_decrypt_sequencer
// Directed bench with an engine model returning address ^ 16'h00FF after 20 cycles.
// Rev    : 1.0
// ============================================================
`default_nettype none

module tb_decrypt_sequencer;
    import decrypt_seq_pkg::*;

    localparam int ARQ       = 16;
    localparam int ADDR      = 10;
    localparam int BUF_DEPTH = 64;
    localparam int TIMEOUT   = 50;
    localparam int E_CYC     = 20;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int total = 0;
    int bad   = 0;
    int pulses = 0;
    logic [ADDR-1:0] addr_q [$];

    logic            eng_run   = 1'b0;
    int              eng_cnt   = 0;
    logic            hang_en   = 1'b0;
    logic [ADDR-1:0] hang_addr = '0;

    decrypt_sequencer_if #(.ARQ(ARQ), .ADDR(ADDR), .BUF_DEPTH(BUF_DEPTH)) bus ();

    decrypt_sequencer #(
        .ARQ       (ARQ),
        .ADDR      (ADDR),
        .BUF_DEPTH (BUF_DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Engine: restarted by eng_rst low, finish level rises on the 20th RUN cycle.
    always @(posedge clk) begin
        if (!bus.eng_rst) begin
            eng_run <= 1'b1;
            eng_cnt <= 1;
        end else if (eng_run) begin
            eng_cnt <= eng_cnt + 1;
        end
    end

    assign bus.eng_finish = eng_run && (eng_cnt >= E_CYC) && !(hang_en && (bus.address == hang_addr));
    assign bus.eng_result = ARQ'(bus.address) ^ 16'h00FF;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic launch(input logic [ADDR-1:0] b, input logic [6:0] n);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.base_addr = b;
        bus.num_words = n;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Called at the first negedge after the accept edge (m = 0).
    task automatic wait_evt(input int budget, input int poke_m,
                            output int ev_m, output bit saw_done, output bit saw_err);
        ev_m = -1;
        saw_done = 1'b0;
        saw_err = 1'b0;
        pulses = 0;
        addr_q.delete();
        for (int m = 0; m < budget; m++) begin
            if (m == 0) begin
                check_eq("busy_rise", 32'(bus.busy), 32'd1);
                check_eq("err_clear", 32'(bus.error), 32'd0);
            end
            if (m == poke_m) begin
                bus.start     = 1'b1;
                bus.base_addr = 10'h155;
                bus.num_words = 7'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (!bus.eng_rst) begin
                pulses++;
                addr_q.push_back(bus.address);
            end
            if (bus.done) begin
                saw_done = 1'b1;
                ev_m = m;
                break;
            end
            if (bus.error) begin
                saw_err = 1'b1;
                ev_m = m;
                break;
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        check_eq("evt_seen", 32'(ev_m >= 0), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input int idx, input logic [ARQ-1:0] exp);
        @(negedge clk);
        bus.rd_addr = idx[5:0];
        @(negedge clk);
        check_eq(tag, 32'(bus.rd_data), 32'(exp));
    endtask

    initial begin
        int ev;
        bit sd;
        bit se;
        logic [ADDR-1:0] t2_addr [3];
        logic [ARQ-1:0]  t2_buf  [3];
        t2_addr = '{10'h3FE, 10'h3FF, 10'h000};
        t2_buf  = '{16'h0301, 16'h0300, 16'h00FF};

        bus.start     = 1'b0;
        bus.base_addr = '0;
        bus.num_words = '0;
        bus.rd_addr   = '0;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_address", 32'(bus.address), 32'd0);
        check_eq("rst_eng_rst", 32'(bus.eng_rst), 32'd1);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_error", 32'(bus.error), 32'd0);
        check_eq("rst_words", 32'(bus.words_done), 32'd0);
        check_eq("rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b1;

        // Base 0, four words
        launch(10'h000, 7'd4);
        wait_evt(200, -1, ev, sd, se);
        check_eq("t1_latency", 32'(ev + 1), 32'd93);
        check_eq("t1_pulses", 32'(pulses), 32'd4);
        for (int i = 0; i < addr_q.size(); i++) check_eq("t1_addr", 32'(addr_q[i]), 32'(i));
        check_eq("t1_words", 32'(bus.words_done), 32'd4);
        @(negedge clk);
        check_eq("t1_done_once", 32'(bus.done), 32'd0);
        check_eq("t1_busy_drop", 32'(bus.busy), 32'd0);
        rd_chk("t1_buf0", 0, 16'h00FF);
        rd_chk("t1_buf1", 1, 16'h00FE);
        rd_chk("t1_buf2", 2, 16'h00FD);
        rd_chk("t1_buf3", 3, 16'h00FC);

        // Address wrap past all-ones
        launch(10'h3FE, 7'd3);
        wait_evt(200, -1, ev, sd, se);
        check_eq("t2_latency", 32'(ev + 1), 32'd70);
        check_eq("t2_pulses", 32'(pulses), 32'd3);
        for (int i = 0; i < addr_q.size(); i++) check_eq("t2_addr", 32'(addr_q[i]), 32'(t2_addr[i]));
        for (int i = 0; i < 3; i++) rd_chk("t2_buf", i, t2_buf[i]);
        rd_chk("t2_buf3_kept", 3, 16'h00FC);

        // Empty batch
        launch(10'h000, 7'd0);
        wait_evt(20, -1, ev, sd, se);
        check_eq("t3_latency", 32'(ev + 1), 32'd1);
        check_eq("t3_pulses", 32'(pulses), 32'd0);
        check_eq("t3_words", 32'(bus.words_done), 32'd0);

        // Oversized count clamps to buffer depth
        launch(10'h000, 7'd100);
        wait_evt(2000, -1, ev, sd, se);
        check_eq("t4_latency", 32'(ev + 1), 32'd1473);
        check_eq("t4_pulses", 32'(pulses), 32'd64);
        check_eq("t4_words", 32'(bus.words_done), 32'd64);
        rd_chk("t4_buf63", 63, 16'h00C0);

        // Engine hangs on word 2
        hang_en   = 1'b1;
        hang_addr = 10'h012;
        launch(10'h010, 7'd4);
        wait_evt(400, -1, ev, sd, se);
        check_eq("t5_err_seen", 32'(se), 32'd1);
        check_eq("t5_no_done", 32'(sd), 32'd0);
        check_eq("t5_fault_cyc", 32'(ev), 32'd98);
        check_eq("t5_words", 32'(bus.words_done), 32'd2);
        check_eq("t5_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_eq("t5_err_sticky", 32'(bus.error), 32'd1);
        check_eq("t5_no_done2", 32'(bus.done), 32'd0);
        hang_en = 1'b0;
        rd_chk("t5_buf1", 1, 16'h00EE);
        rd_chk("t5_buf2_kept", 2, 16'h00FD);
        launch(10'h000, 7'd1);
        wait_evt(100, -1, ev, sd, se);
        check_eq("t5b_latency", 32'(ev + 1), 32'd24);
        check_eq("t5b_error", 32'(bus.error), 32'd0);

        // Reset during RUN of word 1
        bus.rd_addr = 6'd5;
        launch(10'h020, 7'd3);
        repeat (30) @(negedge clk);
        check_eq("t6_busy_pre", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_address", 32'(bus.address), 32'd0);
        check_eq("t6_eng_rst", 32'(bus.eng_rst), 32'd1);
        check_eq("t6_busy", 32'(bus.busy), 32'd0);
        check_eq("t6_done", 32'(bus.done), 32'd0);
        check_eq("t6_error", 32'(bus.error), 32'd0);
        check_eq("t6_words", 32'(bus.words_done), 32'd0);
        check_eq("t6_rd_data", 32'(bus.rd_data), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t6_rd_resume", 32'(bus.rd_data), 32'h00FA);
        rd_chk("t6_buf0", 0, 16'h00DF);
        rd_chk("t6_buf1_kept", 1, 16'h00EE);

        // Start while busy is ignored
        launch(10'h000, 7'd2);
        wait_evt(200, 10, ev, sd, se);
        check_eq("t7_latency", 32'(ev + 1), 32'd47);
        check_eq("t7_words", 32'(bus.words_done), 32'd2);
        check_eq("t7_pulses", 32'(pulses), 32'd2);

        // Start together with reset: reset wins
        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = 7'd2;
        rst           = 1'b0;
        @(negedge clk);
        rst       = 1'b1;
        bus.start = 1'b0;
        check_eq("t8_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check_eq("t8_busy2", 32'(bus.busy), 32'd0);

        // Start in FINISH ignored, start in the following cycle accepted
        launch(10'h000, 7'd1);
        wait_evt(100, -1, ev, sd, se);
        check_eq("t9_latency", 32'(ev + 1), 32'd24);
        bus.start     = 1'b1;
        bus.base_addr = 10'h040;
        bus.num_words = 7'd1;
        @(negedge clk);
        check_eq("t9_fin_ignored", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        wait_evt(100, -1, ev, sd, se);
        check_eq("t9b_latency", 32'(ev + 1), 32'd24);
        check_eq("t9b_words", 32'(bus.words_done), 32'd1);
        rd_chk("t9b_buf0", 0, 16'h00BF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
